// File: rtl/wb_stage.sv
// wb_stage -- RV32I writeback stage.
// Holds the MEM/WB pipeline register, picks the writeback source, extracts and
// extends load data, stalls MEM while a load response is outstanding, and
// counts retired instructions.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   mem_valid/mem_ready  MEM->WB handshake (transfer = valid & ready)
//   mem_*                instruction fields from MEM
//   dmem_rvalid/rdata    load response from data memory
//   wr_en/addr/data      register-file write port
//   instret              retired-instruction counter (CNT_W bits, wraps)
module wb_stage #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd_addr,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [31:0]      mem_alu_result,
  input  logic [31:0]      mem_pc_plus4,
  input  logic [31:0]      mem_imm,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_LD} state_t;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_LD  = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  state_t      state_q, state_d;
  logic        reg_write_q;
  logic [4:0]  rd_q;
  logic [1:0]  sel_q;
  logic [2:0]  f3_q;
  logic [31:0] alu_q, pc4_q, imm_q, ld_q;
  logic        accept, xfer;

  // Load byte/halfword extraction; reserved funct3 codes behave as LW.
  function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                           input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_ext = {24'h0, sh[7:0]};
      3'b001:  load_ext = off[1] ? {{16{word[31]}}, word[31:16]}
                                 : {{16{word[15]}}, word[15:0]};
      3'b101:  load_ext = off[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
      default: load_ext = word;
    endcase
  endfunction

  // Ready is derived only from state and reset so the handshake has no
  // combinational path through mem_valid.
  assign accept    = !rst && (state_q != WAIT_LD);
  assign mem_ready = accept;
  assign xfer      = mem_valid & accept;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WRITE: begin
        if (xfer) state_d = (mem_wb_sel == SEL_LD) ? WAIT_LD : WRITE;
        else      state_d = IDLE;
      end
      WAIT_LD:   if (dmem_rvalid) state_d = WRITE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      sel_q       <= '0;
      f3_q        <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
      ld_q        <= '0;
      instret     <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        reg_write_q <= mem_reg_write;
        rd_q        <= mem_rd_addr;
        sel_q       <= mem_wb_sel;
        f3_q        <= mem_funct3;
        alu_q       <= mem_alu_result;
        pc4_q       <= mem_pc_plus4;
        imm_q       <= mem_imm;
      end
      if (state_q == WAIT_LD && dmem_rvalid)
        ld_q <= load_ext(f3_q, alu_q[1:0], dmem_rdata);
      if (state_q == WRITE)
        instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == WRITE && !rst) begin
      wr_en   = reg_write_q & (rd_q != 5'd0);
      wr_addr = rd_q;
      case (sel_q)
        SEL_ALU: wr_data = alu_q;
        SEL_LD:  wr_data = ld_q;
        SEL_PC4: wr_data = pc4_q;
        default: wr_data = imm_q;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model. A second instance
// built with a 4-bit counter shares the stimulus to exercise wrap-around.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_reg_write = 1'b0, dmem_rvalid = 1'b0;
  logic [4:0]  mem_rd_addr = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [31:0] mem_alu_result = '0, mem_pc_plus4 = '0, mem_imm = '0, dmem_rdata = '0;
  logic        mem_ready, wr_en, mem_ready4, wr_en4;
  logic [4:0]  wr_addr, wr_addr4;
  logic [31:0] wr_data, wr_data4;
  logic [63:0] instret;
  logic [3:0]  instret4;

  wb_stage #(.CNT_W(64)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
    .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .mem_imm(mem_imm), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .instret(instret));

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready4),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
    .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .mem_imm(mem_imm), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .instret(instret4));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Stimulus shadow, applied to the DUT inputs at the falling edge.
  logic        s_rst, s_valid, s_rw, s_rvalid;
  logic [4:0]  s_rd;
  logic [1:0]  s_sel;
  logic [2:0]  s_f3;
  logic [31:0] s_alu, s_pc4, s_imm, s_rdata;

  // Model: an instruction is either waiting for its load data or due to
  // retire in the coming cycle with a known result.
  bit          m_wait, m_ret, m_rw;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_val;
  longint unsigned m_cnt;

  // Last observed write port, for scenario-level spot checks.
  logic        o_en;
  logic [31:0] o_data;

  function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] word);
    int unsigned b, h;
    b = (word >> (8 * (addr % 4))) % 256;
    h = (word >> (16 * ((addr / 2) % 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
      3'd5:    return 32'(h);
      default: return word;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    s_rst = 0; s_valid = 0; s_rw = 0; s_rvalid = 0; s_rd = 0; s_sel = 0; s_f3 = 0;
    s_alu = 0; s_pc4 = 0; s_imm = 0; s_rdata = 0;
  endtask

  task automatic cyc();
    logic e_en; logic [4:0] e_addr; logic [31:0] e_data;
    @(negedge clk);
    rst = s_rst; mem_valid = s_valid; mem_reg_write = s_rw; mem_rd_addr = s_rd;
    mem_wb_sel = s_sel; mem_funct3 = s_f3; mem_alu_result = s_alu; mem_pc_plus4 = s_pc4;
    mem_imm = s_imm; dmem_rvalid = s_rvalid; dmem_rdata = s_rdata;
    #1;
    e_en = 0; e_addr = 0; e_data = 0;
    if (m_ret && !s_rst) begin
      e_en = m_rw && (m_rd != 0); e_addr = m_rd; e_data = m_val;
    end
    chk("mem_ready", mem_ready, !s_rst && !m_wait);
    chk("wr_en", wr_en, e_en);
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", wr_data, e_data);
    chk("instret", instret, m_cnt);
    chk("instret4", instret4, m_cnt % 16);
    o_en = wr_en; o_data = wr_data;
    @(posedge clk);
    if (s_rst) begin
      m_wait = 0; m_ret = 0; m_cnt = 0;
    end else begin
      if (m_ret) m_cnt++;
      m_ret = 0;
      if (m_wait) begin
        if (s_rvalid) begin
          m_val = ld_ext(m_f3, m_addr, s_rdata); m_wait = 0; m_ret = 1;
        end
      end else if (s_valid) begin
        m_rw = s_rw; m_rd = s_rd; m_f3 = s_f3; m_addr = s_alu;
        case (s_sel)
          2'd0: begin m_val = s_alu; m_ret = 1; end
          2'd2: begin m_val = s_pc4; m_ret = 1; end
          2'd3: begin m_val = s_imm; m_ret = 1; end
          default: m_wait = 1;
        endcase
      end
    end
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] v);
    idle_in(); s_valid = 1; s_rw = 1; s_rd = rd; s_sel = 0; s_alu = v; cyc();
  endtask

  // Load issued, response returned 'lat' cycles after transfer, then the
  // write cycle; returns the data seen on the write port.
  task automatic load_op(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, input int lat);
    idle_in(); s_valid = 1; s_rw = 1; s_rd = 5'd7; s_sel = 1; s_f3 = f3; s_alu = addr; cyc();
    for (int i = 1; i < lat; i++) begin
      idle_in(); cyc(); chk("ld_stall", mem_ready, 1'b0);
    end
    idle_in(); s_rvalid = 1; s_rdata = word; cyc(); chk("ld_stall", mem_ready, 1'b0);
    idle_in(); cyc();
  endtask

  initial begin
    m_wait = 0; m_ret = 0; m_cnt = 0; m_rw = 0; m_rd = 0; m_f3 = 0; m_addr = 0; m_val = 0;
    idle_in();

    // Reset for two cycles, then idle.
    s_rst = 1; cyc(); cyc();
    idle_in(); cyc();
    chk("idle_ready", mem_ready, 1'b1);
    chk("idle_instret", instret, 64'd0);

    // Back-to-back ALU ops.
    alu_op(5'd1, 32'h11); alu_op(5'd2, 32'h22); alu_op(5'd3, 32'h33);
    idle_in(); cyc(); cyc();
    chk("b2b_instret", instret, 64'd3);

    load_op(3'd0, 32'h1003, 32'h80FF_FF7F, 3);
    chk("lb_data", o_data, 32'hFFFF_FF80);
    load_op(3'd4, 32'h1003, 32'h80FF_FF7F, 3);
    chk("lbu_data", o_data, 32'h0000_0080);
    load_op(3'd5, 32'h1002, 32'h80FF_FF7F, 3);
    chk("lhu_data", o_data, 32'h0000_80FF);
    load_op(3'd1, 32'h1001, 32'h1234_8765, 1);
    chk("lh_data", o_data, 32'hFFFF_8765);
    load_op(3'd7, 32'h1003, 32'hCAFE_F00D, 2);
    chk("lres_data", o_data, 32'hCAFE_F00D);

    // JAL rd=1, then LUI rd=0.
    idle_in(); s_valid = 1; s_rw = 1; s_rd = 1; s_sel = 2; s_pc4 = 32'h104; cyc();
    idle_in(); s_valid = 1; s_rw = 1; s_rd = 0; s_sel = 3; s_imm = 32'hABCD_E000; cyc();
    chk("jal_data", o_data, 32'h104);
    idle_in(); cyc();
    chk("lui_rd0_en", o_en, 1'b0);
    idle_in(); cyc();
    chk("lui_instret", instret, m_cnt);

    // Reset while waiting for load data; the late response must be ignored.
    idle_in(); s_valid = 1; s_rw = 1; s_rd = 5; s_sel = 1; s_alu = 32'h40; cyc();
    idle_in(); cyc();
    idle_in(); s_rst = 1; cyc();
    idle_in(); s_rvalid = 1; s_rdata = 32'h5555_5555; cyc();
    idle_in(); cyc();
    chk("rst_ld_en", o_en, 1'b0);
    chk("rst_ld_instret", instret, 64'd0);

    // 17 retires on the 4-bit counter wrap to 1.
    for (int i = 0; i < 17; i++) alu_op(5'(i + 1), 32'(i));
    idle_in(); cyc(); cyc();
    chk("wrap_instret4", instret4, 4'd1);
    chk("wrap_instret", instret, 64'd17);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      s_rst    = ($urandom_range(0, 39) == 0);
      s_valid  = ($urandom_range(0, 3) != 0);
      s_rw     = ($urandom_range(0, 3) != 0);
      s_rd     = 5'($urandom_range(0, 31));
      s_sel    = 2'($urandom_range(0, 3));
      s_f3     = 3'($urandom_range(0, 7));
      s_alu    = $urandom; s_pc4 = $urandom; s_imm = $urandom;
      s_rvalid = ($urandom_range(0, 2) == 0);
      s_rdata  = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage RV32I pipeline: the writer that drives the register file's write port (`wr_en`/`wr_addr`/`wr_data`). Holds the MEM/WB pipeline register, selects the writeback source, aligns and sign-extends load data returned by data memory, and stalls MEM while a load response is outstanding. Also maintains the retired-instruction counter.

## Interface
- `CNT_W`, 64, width of `instret` counter
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `mem_valid`  in  1  MEM stage presents an instruction
- `mem_ready`  out  1  WB accepts this cycle (transfer = `mem_valid & mem_ready`)
- `mem_reg_write`  in  1  instruction writes rd
- `mem_rd_addr`  in  5  destination register
- `mem_wb_sel`  in  2  00 ALU result, 01 load, 10 PC+4, 11 immediate
- `mem_funct3`  in  3  load type (valid when `mem_wb_sel`=01)
- `mem_alu_result`  in  32  ALU result / load address
- `mem_pc_plus4`  in  32  link value
- `mem_imm`  in  32  U-type immediate
- `dmem_rvalid`  in  1  load response valid
- `dmem_rdata`  in  32  raw aligned word from data memory
- `wr_en`  out  1  register-file write enable
- `wr_addr`  out  5  register-file write address
- `wr_data`  out  32  register-file write data
- `instret`  out  CNT_W  retired instructions

## Operation
- States: IDLE, WRITE, WAIT_LD (registered).
- IDLE: `mem_ready`=1. On transfer: capture all `mem_*` fields; go WAIT_LD if `mem_wb_sel`=01, else WRITE.
- WRITE: retire the held instruction. `wr_en` = `reg_write & (rd != 0)`; `wr_addr` = rd; `wr_data` = selected result. `mem_ready`=1; on a transfer in the same cycle go WRITE/WAIT_LD per the new instruction, else IDLE.
- WAIT_LD: `mem_ready`=0. On `dmem_rvalid`: capture extracted load value, go WRITE. Otherwise remain.
- Load extraction uses held `alu_result[1:0]`:
  - 000 LB / 100 LBU: byte at offset [1:0], sign-/zero-extend.
  - 001 LH / 101 LHU: halfword selected by bit [1] (bit [0] ignored), sign-/zero-extend.
  - 010 LW and reserved codes 011/110/111: full word, offset ignored.
- Outside WRITE: `wr_en`=0, `wr_addr`=0, `wr_data`=0.
- `instret` increments by 1 in every WRITE cycle, independent of `reg_write`/rd; wraps modulo 2^CNT_W.
- `dmem_rvalid` outside WAIT_LD is ignored.

## Timing
- Reset (rst high at a clock edge): state IDLE, held fields cleared, `instret`=0. While `rst` is high, `mem_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
- Non-load: transfer at cycle N -> `wr_en` in cycle N+1; sustained throughput 1 instr/cycle.
- Load: transfer at N, `dmem_rvalid` at M≥N+1 -> write in M+1. `mem_ready` low from N+1 through M inclusive.
- Register-file write lands on the edge ending the WRITE cycle; same-cycle read bypass is the register file's responsibility.
- Reset in WAIT_LD or WRITE: instruction discarded, no write, no `instret` increment; a late `dmem_rvalid` after reset is ignored.
- rd=0 with `reg_write`=1: `wr_en` stays 0, instruction still retires.

## Test plan
- Reset then idle: `rst` 2 cycles -> `wr_en`=0, `instret`=0, `mem_ready`=0 during reset, 1 after.
- Back-to-back ALU ops x1=0x11, x2=0x22, x3=0x33 on consecutive cycles -> `wr_en` high 3 consecutive cycles, addrs 1,2,3, data matching; `instret`=3.
- LB from addr 0x1003, `dmem_rdata`=0x80FF_FF7F, rvalid 3 cycles after transfer -> `mem_ready` low 3 cycles; writes 0xFFFF_FF80. Same with LBU -> 0x0000_0080; LHU addr 0x1002 -> 0x0000_80FF.
- JAL rd=1 `mem_pc_plus4`=0x104 -> wr_data 0x104; LUI rd=0 -> `wr_en`=0, `instret` still increments.
- Reset asserted while in WAIT_LD, rvalid arrives after reset -> no write, `instret`=0.
- `instret` preloaded via CNT_W=4 build, 17 retires -> `instret`=1 (wrap).
